tt_host_reg_responder: RTL and testbench
========================================

// Module: tt_host_reg_responder
// PURPOSE
//   Chip-side responder for the byte-wide host port of a tt_um_* top.
//   The external host (cocotb bench or board MCU) drives a byte on ui_in and
//   toggles req (uio_in[0]). This block then writes or reads a small register
//   file and answers on uo_out, toggling ack (uio_out[0]).
//   It sits between the top-level pins and the user logic, which consumes regs_flat.
// PARAMETERS
//   NREGS     8      number of 8-bit registers (1..126)
//   TIMEOUT   1024   cycles allowed in S_DATA before abort (>=4)
//   RST_VAL   8'h00  reset value of every register
// PORTS
//   clk        in   1          single clock; all logic on rising edge
//   reset      in   1          synchronous, active-high reset
//   ui_in      in   8          host byte; stable from before req toggle until ack toggles
//   req_in     in   1          host request, 2-phase toggle, asynchronous to clk
//   uo_out     out  8          response byte
//   ack_out    out  1          2-phase acknowledge, one toggle per accepted byte
//   err_out    out  1          sticky error flag
//   regs_flat  out  8*NREGS    register file, reg i at [8*i+7:8*i]
// BEHAVIOUR
//   Reset (reset=1 at a clk edge): uo_out=0, ack_out=0, err_out=0, regs=RST_VAL,
//     state=S_CMD, sync flops=0, timeout counter=0. Applies mid-transaction:
//     any partial write is dropped. The host holds req_in=0 while reset is high.
//   Sync: req_in -> s1 -> s2 -> s3 (3 flops). edge = s2 ^ s3.
//     ui_in is sampled in the cycle edge=1.
//   Latency: ack_out toggles, and uo_out updates, on the 3rd rising clk edge
//     after req_in is first sampled changed. At most one byte is handled per edge.
//   Command byte (S_CMD): cmd[7]=W, cmd[6:0]=A.
//     W=0, A<NREGS   : uo_out<=regs[A]; toggle ack; stay in S_CMD.
//     W=0, A=7'h7F   : uo_out<={7'b0,err_out}; err_out<=0; toggle ack.
//     W=0, other A   : uo_out<=8'hEE; err_out<=1; toggle ack.
//     W=1            : latch A; toggle ack; uo_out unchanged; go to S_DATA;
//                      clear timeout counter.
//   Data byte (S_DATA) on edge: if A<NREGS then regs[A]<=ui_in, else err_out<=1
//     and no write. Toggle ack; uo_out unchanged; go to S_CMD.
//   Timeout: in S_DATA the counter increments every cycle without an edge.
//     When it reaches TIMEOUT-1: go to S_CMD, err_out<=1, no ack toggle.
//     A later edge is then parsed as a command.
//   err_out set and clear in the same cycle (status read that also errors):
//     not possible by encoding. A set from timeout in the same cycle wins over clear.
//   regs_flat is registered and changes the cycle the write is applied.
//   No other register changes are caused by this block.
// TESTING
//   1 reset, then read A=0..NREGS-1 -> each uo_out=RST_VAL, ack toggles once per read.
//   2 write cmd 8'h83, data 8'hA5, then read 8'h03 -> uo_out=8'hA5,
//     regs_flat[31:24]=8'hA5, 3 ack toggles, each 3 clks after its req toggle.
//   3 read 8'h10 with NREGS=8 -> uo_out=8'hEE, err_out=1; read 8'h7F -> uo_out=8'h01,
//     err_out=0; read 8'h7F again -> uo_out=8'h00.
//   4 write cmd 8'h81, then no req for TIMEOUT clks -> err_out=1, state S_CMD,
//     no 2nd ack; next byte 8'h01 (read) -> uo_out=old reg1 value.
//   5 write cmd 8'h82, assert reset for 1 clk, host req=0, then read 8'h02
//     -> uo_out=RST_VAL, ack_out restarts from 0.
//   6 req toggled with random 0-5 clk host delays, and req changing near clk edge,
//     over 200 random ops -> scoreboard matches regs and uo_out, ack count = req count.

Source files
------------

// File: rtl/tt_host_reg_responder.sv
// Byte-wide host register responder: 2-phase req/ack handshake on a toggle
// input, a small register file exposed on regs_flat, and a sticky error flag.
module tt_host_reg_responder #(
  parameter int         NREGS   = 8,
  parameter int         TIMEOUT = 1024,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           ui_in,
  input  logic                 req_in,
  output logic [7:0]           uo_out,
  output logic                 ack_out,
  output logic                 err_out,
  output logic [8*NREGS-1:0]   regs_flat
);

  localparam int              CW       = $clog2(TIMEOUT);
  localparam logic [6:0]      NREGS_A  = 7'(NREGS);
  localparam logic [6:0]      STATUS_A = 7'h7F;
  localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {S_CMD = 1'b0, S_DATA = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 s1_q, s2_q, s3_q;
  logic                 req_edge;
  logic [6:0]           addr_q, addr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           uo_q, uo_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [8*NREGS-1:0]   regs_q, regs_d;

  assign req_edge = s2_q ^ s3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      state_q <= S_CMD;
      addr_q  <= 7'd0;
      cnt_q   <= '0;
      uo_q    <= 8'h00;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      regs_q  <= {NREGS{RST_VAL}};
    end else begin
      s1_q    <= req_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      uo_q    <= uo_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
    end
  end

  // Edge handling has priority over the timeout, so a byte arriving on the
  // last allowed cycle is still accepted as data.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    uo_d    = uo_q;
    ack_d   = ack_q;
    err_d   = err_q;
    regs_d  = regs_q;
    case (state_q)
      S_CMD: begin
        if (req_edge) begin
          ack_d = ~ack_q;
          if (ui_in[7]) begin
            addr_d  = ui_in[6:0];
            cnt_d   = '0;
            state_d = S_DATA;
          end else if (ui_in[6:0] < NREGS_A) begin
            uo_d = regs_q[8*int'(ui_in[6:0]) +: 8];
          end else if (ui_in[6:0] == STATUS_A) begin
            uo_d  = {7'b0000000, err_q};
            err_d = 1'b0;
          end else begin
            uo_d  = 8'hEE;
            err_d = 1'b1;
          end
        end else begin
          state_d = S_CMD;
        end
      end
      S_DATA: begin
        if (req_edge) begin
          ack_d   = ~ack_q;
          state_d = S_CMD;
          if (addr_q < NREGS_A) begin
            regs_d[8*int'(addr_q) +: 8] = ui_in;
          end else begin
            err_d = 1'b1;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_CMD;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_CMD;
      end
    endcase
  end

  assign uo_out    = uo_q;
  assign ack_out   = ack_q;
  assign err_out   = err_q;
  assign regs_flat = regs_q;

endmodule

// File: tb/tb_tt_host_reg_responder.sv
// Scoreboard bench for tt_host_reg_responder: a host model toggles req, the
// expected response is queued per byte and compared when ack toggles.
module tb_tt_host_reg_responder;

  localparam int         NREGS   = 8;
  localparam int         TIMEOUT = 16;
  localparam logic [7:0] RST     = 8'h3C;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [7:0]           ui_in;
  logic                 req_in;
  logic [7:0]           uo_out;
  logic                 ack_out;
  logic                 err_out;
  logic [8*NREGS-1:0]   regs_flat;

  tt_host_reg_responder #(.NREGS(NREGS), .TIMEOUT(TIMEOUT), .RST_VAL(RST)) dut (
    .clk(clk), .reset(reset), .ui_in(ui_in), .req_in(req_in),
    .uo_out(uo_out), .ack_out(ack_out), .err_out(err_out), .regs_flat(regs_flat)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] m_regs [NREGS];
  logic       m_err, m_ack, m_data;
  logic [6:0] m_addr;
  logic [7:0] m_uo;
  logic [7:0] exp_q [$];

  function automatic logic [8*NREGS-1:0] m_flat();
    logic [8*NREGS-1:0] f;
    for (int i = 0; i < NREGS; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = RST;
    m_err = 1'b0; m_ack = 1'b0; m_data = 1'b0; m_addr = 7'd0; m_uo = 8'h00;
  endtask

  task automatic model_step(input logic [7:0] b);
    if (!m_data) begin
      if (b[7]) begin
        m_addr = b[6:0];
        m_data = 1'b1;
      end else if (int'(b[6:0]) < NREGS) begin
        m_uo = m_regs[int'(b[6:0])];
      end else if (b[6:0] == 7'h7F) begin
        m_uo  = {7'b0000000, m_err};
        m_err = 1'b0;
      end else begin
        m_uo  = 8'hEE;
        m_err = 1'b1;
      end
    end else begin
      if (int'(m_addr) < NREGS) m_regs[int'(m_addr)] = b;
      else m_err = 1'b1;
      m_data = 1'b0;
    end
    m_ack = ~m_ack;
  endtask

  // Host transaction: wait, drive byte, toggle req, then wait (bounded) for ack.
  task automatic do_op(input logic [7:0] b, input int dly, input int sub, output int lat);
    logic       ack_prev;
    logic [7:0] exp_uo;
    repeat (dly) @(negedge clk);
    if (sub > 0) #(sub);
    ack_prev = ack_out;
    ui_in  = b;
    req_in = ~req_in;
    model_step(b);
    exp_q.push_back(m_uo);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ack_out === ack_prev && lat < 20);
    exp_uo = exp_q.pop_front();
    n_total++;
    if (ack_out === ack_prev) begin
      $display("FAIL ack_wait byte=%02h: ack_out stayed %b for %0d clks, required a toggle", b, ack_out, lat);
    end else begin
      n_pass++;
      n_total++;
      if (uo_out !== exp_uo) $display("FAIL uo_out byte=%02h: got %02h, required %02h", b, uo_out, exp_uo);
      else n_pass++;
      n_total++;
      if (ack_out !== m_ack) $display("FAIL ack_level byte=%02h: got %b, required %b", b, ack_out, m_ack);
      else n_pass++;
      n_total++;
      if (err_out !== m_err) $display("FAIL err_out byte=%02h: got %b, required %b", b, err_out, m_err);
      else n_pass++;
      n_total++;
      if (regs_flat !== m_flat()) $display("FAIL regs_flat byte=%02h: got %h, required %h", b, regs_flat, m_flat());
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b1; req_in = 1'b0; ui_in = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    n_total++;
    if (uo_out !== 8'h00 || ack_out !== 1'b0 || err_out !== 1'b0)
      $display("FAIL reset_outputs: got uo=%02h ack=%b err=%b, required 00/0/0", uo_out, ack_out, err_out);
    else n_pass++;
    n_total++;
    if (regs_flat !== {NREGS{RST}}) $display("FAIL reset_regs: got %h, required %h", regs_flat, {NREGS{RST}});
    else n_pass++;
    for (int a = 0; a < NREGS; a++) begin
      do_op(8'(a), 1, 0, lat);
      n_total++;
      if (uo_out !== RST) $display("FAIL reset_read%0d: got %02h, required %02h", a, uo_out, RST);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [7:0] ops [3];
    ops[0] = 8'h83; ops[1] = 8'hA5; ops[2] = 8'h03;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], 2, 0, lat);
      n_total++;
      if (lat !== 3) $display("FAIL latency op%0d: got %0d clks, required 3", i, lat);
      else n_pass++;
    end
    n_total++;
    if (uo_out !== 8'hA5 || regs_flat[31:24] !== 8'hA5)
      $display("FAIL write_read: got uo=%02h reg3=%02h, required A5/A5", uo_out, regs_flat[31:24]);
    else n_pass++;
  endtask

  task automatic test_error_status();
    int lat;
    do_op(8'h10, 1, 0, lat);
    n_total++;
    if (uo_out !== 8'hEE || err_out !== 1'b1) $display("FAIL bad_addr: got uo=%02h err=%b, required EE/1", uo_out, err_out);
    else n_pass++;
    do_op(8'h7F, 1, 0, lat);
    n_total++;
    if (uo_out !== 8'h01 || err_out !== 1'b0) $display("FAIL status1: got uo=%02h err=%b, required 01/0", uo_out, err_out);
    else n_pass++;
    do_op(8'h7F, 1, 0, lat);
    n_total++;
    if (uo_out !== 8'h00) $display("FAIL status2: got uo=%02h, required 00", uo_out);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int lat;
    do_op(8'h81, 1, 0, lat);
    do_op(8'h5A, 1, 0, lat);
    do_op(8'h81, 1, 0, lat);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    n_total++;
    if (err_out !== 1'b0) $display("FAIL timeout_early: got err=%b, required 0", err_out);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (err_out !== 1'b1) $display("FAIL timeout_err: got err=%b, required 1", err_out);
    else n_pass++;
    m_err = 1'b1; m_data = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (ack_out !== m_ack) $display("FAIL timeout_noack: got ack=%b, required %b", ack_out, m_ack);
    else n_pass++;
    do_op(8'h01, 1, 0, lat);
    n_total++;
    if (uo_out !== 8'h5A) $display("FAIL timeout_cmd: got uo=%02h, required 5A", uo_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    do_op(8'h82, 1, 0, lat);
    @(negedge clk);
    reset = 1'b1; req_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    n_total++;
    if (ack_out !== 1'b0 || uo_out !== 8'h00 || err_out !== 1'b0 || regs_flat !== m_flat())
      $display("FAIL mid_reset: got ack=%b uo=%02h err=%b regs=%h, required 0/00/0/%h",
               ack_out, uo_out, err_out, regs_flat, m_flat());
    else n_pass++;
    do_op(8'h02, 2, 0, lat);
    n_total++;
    if (uo_out !== RST || ack_out !== 1'b1) $display("FAIL mid_reset_read: got uo=%02h ack=%b, required %02h/1", uo_out, ack_out, RST);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat;
    int a;
    logic [7:0] b;
    for (int i = 0; i < 200; i++) begin
      if (m_data) begin
        b = 8'($urandom_range(0, 255));
      end else begin
        a = int'($urandom_range(0, 10));
        if (a == 10) a = 127;
        b = {1'($urandom_range(0, 1)), 7'(a)};
      end
      do_op(b, int'($urandom_range(0, 5)), int'($urandom_range(0, 9)), lat);
    end
  endtask

  initial begin
    int lat;
    test_reset();
    test_write_read();
    test_error_status();
    test_timeout();
    test_reset_mid();
    test_random();
    if (m_data) do_op(8'h00, 1, 0, lat);
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
